// File: rtl/key_conditioner.sv
// Synchronizes and debounces the start/prev pushbuttons; emits a start pulse and a prev toggle.
// Optional start-key auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 5000000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_key_start_n,
   input  logic       i_key_prev_n,
   output logic       o_start,
   output logic       o_prev_random,
   output logic [1:0] o_key_state
);

   typedef enum logic [1:0] {StReleased, StPressChk, StPressed, StReleaseChk} key_fsm_e;

   localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Index 0 = start key, 1 = prev key throughout.
   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       pressed;
   key_fsm_e         state_q [2];
   key_fsm_e         state_d [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       press_evt;
   logic [1:0]       key_state;
   logic             start_evt;
   logic             start_q, start_d;
   logic             prev_random_q, prev_random_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {i_key_prev_n, i_key_start_n};
         sync2_q <= sync1_q;
      end
   end

   assign pressed = ~sync2_q;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 2; k++) begin
            state_q[k] <= StReleased;
            cnt_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   // Next-state logic; the counter is cleared on every state entry
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         unique case (state_q[k])
            StReleased: begin
               if (pressed[k]) begin
                  state_d[k] = StPressChk;
                  cnt_d[k]   = '0;
               end
            end
            StPressChk: begin
               if (!pressed[k]) begin
                  state_d[k] = StReleased;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == DbLast) begin
                  state_d[k] = StPressed;
                  cnt_d[k]   = '0;
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
            StPressed: begin
               if (!pressed[k]) begin
                  state_d[k] = StReleaseChk;
                  cnt_d[k]   = '0;
               end
            end
            StReleaseChk: begin
               if (pressed[k]) begin
                  state_d[k] = StPressed;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == DbLast) begin
                  state_d[k] = StReleased;
                  cnt_d[k]   = '0;
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      key_state = '0;
      press_evt = '0;
      for (int k = 0; k < 2; k++) begin
         key_state[k] = (state_q[k] == StPressed) || (state_q[k] == StReleaseChk);
         press_evt[k] = (state_q[k] == StPressChk) && pressed[k] && (cnt_q[k] == DbLast);
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYCLES - 1);

   logic             stay_pressed;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             repeat_q, repeat_d;
   logic             repeat_evt;

   assign stay_pressed = (state_q[0] == StPressed) && (state_d[0] == StPressed);

   // First wait is HOLD_CYCLES, then every REPEAT_CYCLES; any exit from StPressed restarts it
   always_comb begin
      hold_cnt_d = '0;
      repeat_d   = 1'b0;
      repeat_evt = 1'b0;
      if (stay_pressed) begin
         repeat_d = repeat_q;
         if (hold_cnt_q == (repeat_q ? RepLast : HoldLast)) begin
            repeat_evt = 1'b1;
            repeat_d   = 1'b1;
         end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_cnt_q <= '0;
         repeat_q   <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         repeat_q   <= repeat_d;
      end
   end

   assign start_evt = press_evt[0] | repeat_evt;
`else
   assign start_evt = press_evt[0];
`endif

   // Start wins over a simultaneous prev event
   always_comb begin
      start_d       = start_evt;
      prev_random_d = prev_random_q;
      if (start_evt) begin
         prev_random_d = 1'b0;
      end else if (press_evt[1]) begin
         prev_random_d = ~prev_random_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         start_q       <= 1'b0;
         prev_random_q <= 1'b0;
      end else begin
         start_q       <= start_d;
         prev_random_q <= prev_random_d;
      end
   end

   assign o_start       = start_q;
   assign o_prev_random = prev_random_q;
   assign o_key_state   = key_state;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: scenario table, hand sequences and random stimulus
// compared every cycle against a run-length reference model.
module tb_key_conditioner;

   localparam int Db   = 8;
   localparam int Hold = 32;
   localparam int Rep  = 8;
`ifdef KEY_AUTOREPEAT_EN
   localparam bit AutoRep = 1'b1;
`else
   localparam bit AutoRep = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_start_n = 1'b1;
   logic       key_prev_n = 1'b1;
   logic       o_start;
   logic       o_prev_random;
   logic [1:0] o_key_state;

   key_conditioner #(
      .DEBOUNCE_CYCLES(Db),
      .HOLD_CYCLES    (Hold),
      .REPEAT_CYCLES  (Rep),
      .CNT_W          (8)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_key_start_n(key_start_n),
      .i_key_prev_n (key_prev_n),
      .o_start      (o_start),
      .o_prev_random(o_prev_random),
      .o_key_state  (o_key_state)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model: a key's accepted level flips after Db+1 consecutive differing samples
   // of the key delayed by two clocks.
   bit m_d1 [2];
   bit m_d2 [2];
   bit m_deb [2];
   int m_run [2];
   int m_since;
   bit m_start, m_prev;

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_d1[k] = 1'b0; m_d2[k] = 1'b0; m_deb[k] = 1'b0; m_run[k] = 0;
      end
      m_since = 0; m_start = 1'b0; m_prev = 1'b0;
   endfunction

   function automatic void model_edge(input bit ks_n, input bit kp_n);
      bit seen [2];
      bit evt [2];
      bit rep;
      seen = m_d2; m_d2 = m_d1; m_d1[0] = !ks_n; m_d1[1] = !kp_n;
      rep = 1'b0;
      for (int k = 0; k < 2; k++) begin
         evt[k] = 1'b0;
         if (seen[k] != m_deb[k]) begin
            m_run[k]++;
            if (m_run[k] == Db + 1) begin
               m_deb[k] = seen[k]; m_run[k] = 0; evt[k] = seen[k];
               if (k == 0) m_since = 0;
            end
         end else begin
            if (k == 0 && m_deb[0]) begin
               if (m_run[0] > 0) m_since = 0;
               else begin
                  m_since++;
                  if (AutoRep && (m_since == Hold ||
                                  (m_since > Hold && (m_since - Hold) % Rep == 0)))
                     rep = 1'b1;
               end
            end
            m_run[k] = 0;
         end
      end
      m_start = evt[0] | rep;
      if (m_start) m_prev = 1'b0;
      else if (evt[1]) m_prev = !m_prev;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   int sc_edge, sc_pulses, sc_first;

   task automatic scen_clear();
      sc_edge = 0; sc_pulses = 0; sc_first = -1;
   endtask

   task automatic step(input bit ks_n, input bit kp_n, input bit rn);
      @(negedge clk);
      key_start_n = ks_n; key_prev_n = kp_n; rst_n = rn;
      @(posedge clk);
      cyc++;
      if (!rn) model_reset();
      else model_edge(ks_n, kp_n);
      #1;
      check("outputs{start,prev,key_state}", int'({o_start, o_prev_random, o_key_state}),
            int'({m_start, m_prev, m_deb[1], m_deb[0]}));
      sc_edge++;
      if (o_start === 1'b1) begin
         sc_pulses++;
         if (sc_first < 0) sc_first = sc_edge;
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      scen_clear();
   endtask

   typedef struct {
      int s_on, s_len, s_bounce;
      int p_on, p_len, p_reps;
      int cycles;
      int exp_pulses, exp_first;
      bit exp_prev;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{0, 40, 0, 0, 0, 0, 60, 1, 11, 1'b0};            // clean start press
      vecs[1] = '{0, 30, 3, 0, 0, 0, 50, 0, -1, 1'b0};            // bouncing start
      vecs[2] = '{0, 0, 0, 0, 12, 3, 100, 0, -1, 1'b1};           // three prev presses
      vecs[3] = '{0, 100, 0, 0, 0, 0, 130, AutoRep ? 9 : 1, 11, 1'b0}; // long hold
      vecs[4] = '{40, 12, 0, 0, 12, 1, 80, 1, 51, 1'b0};          // start clears prev

      model_reset();
      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int c = 0; c < vecs[v].cycles; c++) begin
            bit sp, pp;
            sp = (c >= vecs[v].s_on) && (c < vecs[v].s_on + vecs[v].s_len) &&
                 (vecs[v].s_bounce == 0 || ((c - vecs[v].s_on) / vecs[v].s_bounce) % 2 == 0);
            pp = 1'b0;
            for (int r = 0; r < vecs[v].p_reps; r++)
               if (c >= vecs[v].p_on + 30 * r && c < vecs[v].p_on + 30 * r + vecs[v].p_len)
                  pp = 1'b1;
            step(!sp, !pp, 1'b1);
         end
         check($sformatf("vec%0d pulse count", v), sc_pulses, vecs[v].exp_pulses);
         check($sformatf("vec%0d first pulse edge", v), sc_first, vecs[v].exp_first);
         check($sformatf("vec%0d prev_random", v), int'(o_prev_random), int'(vecs[v].exp_prev));
      end

      // Both keys fall together while prev_random is set
      do_reset();
      for (int c = 0; c < 40; c++) step(1'b1, !(c < 12), 1'b1);
      for (int i = 1; i <= 15; i++) begin
         step(1'b0, 1'b0, 1'b1);
         if (i == 10) check("simul before edge", int'({o_start, o_prev_random}), 1);
         if (i == 11) check("simul start wins", int'({o_start, o_prev_random}), 2);
      end
      for (int c = 0; c < 20; c++) step(1'b1, 1'b1, 1'b1);

      // Reset asserted mid-debounce with the start key held throughout
      do_reset();
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("in reset outputs", int'({o_start, o_prev_random, o_key_state}), 0);
      scen_clear();
      for (int i = 1; i <= 30; i++) begin
         step(1'b0, 1'b1, 1'b1);
         if (i == 11) check("post-reset pulse", int'(o_start), 1);
      end
      check("post-reset pulse count", sc_pulses, AutoRep ? 0 + 1 : 1);
      for (int c = 0; c < 20; c++) step(1'b1, 1'b1, 1'b1);

      // Random key activity with occasional resets
      begin
         bit ks, kp;
         int ls, lp;
         ks = 1'b1; kp = 1'b1; ls = 0; lp = 0;
         for (int c = 0; c < 4000; c++) begin
            if (ls == 0) begin ks = !ks; ls = $urandom_range(1, 20 + (c % 3) * 15); end
            if (lp == 0) begin kp = !kp; lp = $urandom_range(1, 25); end
            ls--; lp--;
            step(ks, kp, ($urandom_range(0, 599) != 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
